// File: rtl/act_scheduler_pkg.sv
// Shared types and helpers for the activation scheduler slice.
package act_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } act_state_t;

  localparam int ACT_DATA_W = 16;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/act_scheduler_if.sv
// Requester, activation-unit and response signals of the activation scheduler.
interface act_scheduler_if
  import act_sched_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = ACT_DATA_W,
  parameter int ID_W   = clog2_min1(N_REQ)
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       act_in;
  logic [DATA_W-1:0]       act_out;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_W-1:0]       rsp_data;
  logic [ID_W-1:0]         rsp_id;
  logic                    busy;

  modport slave (
    input  req_valid, req_data, act_out, rsp_ready,
    output req_ready, act_in, rsp_valid, rsp_data, rsp_id, busy
  );

  modport master (
    output req_valid, req_data, act_out, rsp_ready,
    input  req_ready, act_in, rsp_valid, rsp_data, rsp_id, busy
  );

endinterface

// File: rtl/act_rr_arb.sv
// Request arbiter: round-robin when ACT_RR_EN is defined, else fixed lowest-index priority.
module act_rr_arb
  import act_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  pointer,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  index
);

`ifndef ACT_RR_EN
  logic ptr_unused_s;
  assign ptr_unused_s = ^pointer;
`endif

  // First asserted requester along the search order wins.
  always_comb begin
    int   c_s;
    logic found_s;
    logic hit_s;
    grant   = '0;
    index   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    c_s     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
`ifdef ACT_RR_EN
      c_s = (int'(pointer) + k) % N_REQ;
`else
      c_s = k - 1;
`endif
      hit_s      = !found_s && req_valid[c_s];
      grant[c_s] = hit_s;
      index      = hit_s ? ID_W'(c_s) : index;
      found_s    = found_s | hit_s;
    end
  end

endmodule

// File: rtl/act_scheduler.sv
// Shares one combinational activation unit among N_REQ requesters.
// ACT_RR_EN selects round-robin arbitration; otherwise fixed priority.
module act_scheduler
  import act_sched_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = ACT_DATA_W,
  parameter int ID_W   = clog2_min1(N_REQ)
) (
  input logic            clk,
  input logic            n_rst,
  act_scheduler_if.slave bus
);

  act_state_t        state_r;
  act_state_t        state_s;
  logic [DATA_W-1:0] op_r;
  logic [ID_W-1:0]   id_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic [ID_W-1:0]   rsp_id_r;
  logic [ID_W-1:0]   ptr_s;
  logic [N_REQ-1:0]  gnt_s;
  logic [ID_W-1:0]   gnt_idx_s;
  logic              grant_en_s;
  logic              any_s;
  logic              fire_s;

  act_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req_valid (bus.req_valid),
    .pointer   (ptr_s),
    .grant     (gnt_s),
    .index     (gnt_idx_s)
  );

  assign any_s = |bus.req_valid;

  // Grants open in IDLE, or in RESP once the held response is taken.
  always_comb begin
    grant_en_s = 1'b0;
    state_s    = state_r;
    case (state_r)
      IDLE: begin
        grant_en_s = 1'b1;
        if (any_s) state_s = EVAL;
        else       state_s = IDLE;
      end
      EVAL: begin
        grant_en_s = 1'b0;
        state_s    = RESP;
      end
      RESP: begin
        grant_en_s = bus.rsp_ready;
        if (bus.rsp_ready && any_s) state_s = EVAL;
        else if (bus.rsp_ready)     state_s = IDLE;
        else                        state_s = RESP;
      end
      default: begin
        grant_en_s = 1'b0;
        state_s    = IDLE;
      end
    endcase
  end

  assign fire_s        = grant_en_s & any_s;
  assign bus.req_ready = grant_en_s ? gnt_s : '0;

  // FSM, operand capture and response capture.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r    <= IDLE;
      op_r       <= '0;
      id_r       <= '0;
      rsp_data_r <= '0;
      rsp_id_r   <= '0;
    end else begin
      state_r <= state_s;
      if (fire_s) begin
        op_r <= bus.req_data[int'(gnt_idx_s)*DATA_W +: DATA_W];
        id_r <= gnt_idx_s;
      end
      if (state_r == EVAL) begin
        rsp_data_r <= bus.act_out;
        rsp_id_r   <= id_r;
      end
    end
  end

`ifdef ACT_RR_EN
  logic [ID_W-1:0] ptr_r;

  // Last winner; the next search begins just after it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr_r <= ID_W'(N_REQ - 1);
    end else if (fire_s) begin
      ptr_r <= gnt_idx_s;
    end
  end

  assign ptr_s = ptr_r;
`else
  assign ptr_s = ID_W'(N_REQ - 1);
`endif

  assign bus.act_in    = op_r;
  assign bus.rsp_valid = (state_r == RESP);
  assign bus.busy      = (state_r != IDLE);
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_id    = rsp_id_r;

endmodule

// File: tb/tb_act_scheduler.sv
// Scoreboard bench for act_scheduler with an inverting activation stub (N_REQ=4).
module tb_act_scheduler;

  logic clk;
  logic n_rst;
  int   checks;
  int   failures;
  int   hs_count;
  int   hs0;
  logic [17:0] exp_q[$];

  act_scheduler_if #(.N_REQ(4)) bus ();

  act_scheduler #(.N_REQ(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  assign bus.act_out = bus.act_in ^ 16'hFFFF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [15:0] d);
    bus.req_data[i*16 +: 16] = d;
  endtask

  task automatic load_all();
    set_data(0, 16'h1111);
    set_data(1, 16'h2222);
    set_data(2, 16'h3333);
    set_data(3, 16'h4444);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
  endtask

  // Response monitor: pops the scoreboard on every accepted response.
  always @(negedge clk) begin
    logic [17:0] exp;
    if (n_rst && bus.rsp_valid && bus.rsp_ready) begin
      hs_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got id=%0d data=%h expected no response", bus.rsp_id, bus.rsp_data);
      end else begin
        exp = exp_q.pop_front();
        if ({bus.rsp_id, bus.rsp_data} !== exp) begin
          failures++;
          $display("FAIL rsp: got id=%0d data=%h expected id=%0d data=%h",
                   bus.rsp_id, bus.rsp_data, exp[17:16], exp[15:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    failures      = 0;
    hs_count      = 0;
    n_rst         = 1'b0;
    bus.req_valid = 4'b0000;
    bus.req_data  = 64'h0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_act_in", bus.act_in, 16'h0000);
    check("rst_rsp_data", bus.rsp_data, 16'h0000);
    check("rst_rsp_id", bus.rsp_id, 2'd0);
    check("rst_req_ready", bus.req_ready, 4'b0000);
    n_rst = 1'b1;
    tick();

    // 1: single request, response two edges after accept
    bus.rsp_ready = 1'b1;
    set_data(2, 16'h1234);
    bus.req_valid = 4'b0100;
    exp_q.push_back({2'd2, 16'hEDCB});
    #2 check("t1_req_ready", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = 4'b0000;
    check("t1_eval_req_ready", bus.req_ready, 4'b0000);
    check("t1_eval_busy", bus.busy, 1'b1);
    check("t1_act_in", bus.act_in, 16'h1234);
    check("t1_eval_rsp_valid", bus.rsp_valid, 1'b0);
    tick();
    check("t1_rsp_valid", bus.rsp_valid, 1'b1);
    tick();
    check("t1_idle_busy", bus.busy, 1'b0);

    // 2: back-to-back, all requesters valid
    do_reset();
    load_all();
`ifdef ACT_RR_EN
    exp_q.push_back({2'd0, 16'hEEEE});
    exp_q.push_back({2'd1, 16'hDDDD});
    exp_q.push_back({2'd2, 16'hCCCC});
    exp_q.push_back({2'd3, 16'hBBBB});
    exp_q.push_back({2'd0, 16'hEEEE});
`else
    repeat (5) exp_q.push_back({2'd0, 16'hEEEE});
`endif
    hs0 = hs_count;
    bus.req_valid = 4'b1111;
    repeat (9) tick();
    bus.req_valid = 4'b0000;
    repeat (2) tick();
    check("t2_resp_count", hs_count - hs0, 5);
    check("t2_idle", bus.busy, 1'b0);

    // 3: backpressure in RESP, grant on release in the same cycle
    bus.rsp_ready = 1'b0;
    set_data(0, 16'h00FF);
    bus.req_valid = 4'b0001;
    exp_q.push_back({2'd0, 16'hFF00});
    tick();
    set_data(3, 16'h0F0F);
    bus.req_valid = 4'b1000;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t3_req_ready", bus.req_ready, 4'b0000);
      check("t3_busy", bus.busy, 1'b1);
      check("t3_rsp_valid", bus.rsp_valid, 1'b1);
      check("t3_rsp_data", bus.rsp_data, 16'hFF00);
      check("t3_rsp_id", bus.rsp_id, 2'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    exp_q.push_back({2'd3, 16'hF0F0});
    #1 check("t3_release_grant", bus.req_ready, 4'b1000);
    tick();
    bus.req_valid = 4'b0000;
    repeat (2) tick();

    // 4: reset in EVAL discards the operation
    set_data(1, 16'h5555);
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b0000;
    n_rst = 1'b0;
    #1;
    check("t4_rsp_valid", bus.rsp_valid, 1'b0);
    check("t4_busy", bus.busy, 1'b0);
    check("t4_act_in", bus.act_in, 16'h0000);
    check("t4_rsp_data", bus.rsp_data, 16'h0000);
    tick();
    n_rst = 1'b1;
    load_all();
    bus.req_valid = 4'b1111;
    exp_q.push_back({2'd0, 16'hEEEE});
    #2 check("t4_restart_grant", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = 4'b0000;
    repeat (2) tick();

    // 5: request withdrawn while a response is held
    bus.rsp_ready = 1'b0;
    set_data(2, 16'h8001);
    bus.req_valid = 4'b0100;
    exp_q.push_back({2'd2, 16'h7FFE});
    tick();
    set_data(1, 16'h2468);
    bus.req_valid = 4'b0010;
    tick();
    check("t5_hold_req_ready", bus.req_ready, 4'b0000);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    bus.rsp_ready = 1'b1;
    #1 check("t5_release_req_ready", bus.req_ready, 4'b0000);
    tick();
    check("t5_busy", bus.busy, 1'b0);
    check("t5_rsp_valid", bus.rsp_valid, 1'b0);
    tick();
    check("t5_still_idle", bus.busy, 1'b0);

    // 6: idle with no requests
    for (int i = 0; i < 20; i++) begin
      check("t6_req_ready", bus.req_ready, 4'b0000);
      check("t6_rsp_valid", bus.rsp_valid, 1'b0);
      check("t6_busy", bus.busy, 1'b0);
      check("t6_act_in", bus.act_in, 16'h8001);
      tick();
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
